// File: rtl/bt656out_ctlif.sv
// CSR bank and frame address sequencer for the BT.656 output DMA; BT656OUT_UNDERRUN_EN adds the underrun counter.
// Latency: every output is registered, one cycle after the input that causes it.
// Backpressure: none; fml_adr holds until next_burst reports the burst as accepted.
module bt656out_ctlif #(
  parameter logic [3:0] csr_addr  = 4'h0,
  parameter int         fml_depth = 26
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [13:0]          csr_a,
  input  logic                 csr_we,
  input  logic [31:0]          csr_di,
  output logic [31:0]          csr_do,
  output logic                 irq,
  output logic                 enable,
  input  logic                 start_of_frame,
  input  logic                 next_burst,
  output logic [fml_depth-1:0] fml_adr,
  output logic                 last_burst,
  input  logic                 underrun
);

  localparam int          BW             = fml_depth - 5;
  localparam logic [14:0] MAX_BURSTS_RST = 15'd12960;

  typedef enum logic {ST_IDLE, ST_FRAME} state_t;

  state_t        state_q, state_d;
  logic          enable_q, enable_d;
  logic [BW-1:0] pend_base_q, pend_base_d;
  logic [BW-1:0] act_base_q, act_base_d;
  logic [BW-1:0] adr_q, adr_d;
  logic [14:0]   max_bursts_q, max_bursts_d;
  logic [14:0]   burst_cnt_q, burst_cnt_d;
  logic [14:0]   done_bursts_q, done_bursts_d;
  logic          last_q, last_d;
  logic          irq_q, irq_d;
  logic [31:0]   csr_do_q, csr_do_d;

  logic csr_sel;
  logic csr_wr;
  logic in_frame;
  logic sof_acc;

  assign csr_sel  = (csr_a[13:10] == csr_addr);
  assign csr_wr   = csr_sel & csr_we;
  assign in_frame = (state_q == ST_FRAME);
  // A frame only starts when enabled and there is something to fetch.
  assign sof_acc  = start_of_frame & enable_q & (max_bursts_q != 15'd0);

  // CSR-writable configuration.
  always_comb begin
    enable_d     = enable_q;
    pend_base_d  = pend_base_q;
    max_bursts_d = max_bursts_q;
    if (csr_wr) begin
      case (csr_a[2:0])
        3'd0:    enable_d     = csr_di[0];
        3'd1:    pend_base_d  = csr_di[fml_depth-1:5];
        3'd2:    max_bursts_d = csr_di[14:0];
        default: ;
      endcase
    end
  end

  // Frame sequencer: start_of_frame always beats next_burst.
  always_comb begin
    state_d       = state_q;
    act_base_d    = act_base_q;
    adr_d         = adr_q;
    burst_cnt_d   = burst_cnt_q;
    done_bursts_d = done_bursts_q;
    last_d        = last_q;
    irq_d         = 1'b0;
    if (sof_acc) begin
      state_d       = ST_FRAME;
      done_bursts_d = burst_cnt_q;
      burst_cnt_d   = '0;
      act_base_d    = pend_base_q;
      adr_d         = pend_base_q;
      last_d        = (max_bursts_q == 15'd1);
    end else if (next_burst && in_frame) begin
      burst_cnt_d = burst_cnt_q + 15'd1;
      if (last_q) begin
        state_d = ST_IDLE;
        last_d  = 1'b0;
        irq_d   = 1'b1;
      end else begin
        adr_d  = adr_q + BW'(1);
        last_d = (({1'b0, burst_cnt_q} + 16'd2) == {1'b0, max_bursts_q});
      end
    end
  end

`ifdef BT656OUT_UNDERRUN_EN
  logic [15:0] urun_cnt_q, urun_cnt_d;

  always_comb begin
    urun_cnt_d = urun_cnt_q;
    if (csr_wr && (csr_a[2:0] == 3'd5)) begin
      urun_cnt_d = '0;
    end else if (underrun && in_frame && (urun_cnt_q != 16'hffff)) begin
      urun_cnt_d = urun_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      urun_cnt_q <= '0;
    end else begin
      urun_cnt_q <= urun_cnt_d;
    end
  end
`else
  logic unused_underrun;
  assign unused_underrun = underrun;
`endif

  logic unused_csr;
  assign unused_csr = ^{csr_a[9:3], csr_di};

  // Read data reflects state before any same-cycle write.
  always_comb begin
    csr_do_d = '0;
    if (csr_sel) begin
      case (csr_a[2:0])
        3'd0:    csr_do_d = {30'd0, in_frame, enable_q};
        3'd1:    csr_do_d = 32'({pend_base_q, 5'd0});
        3'd2:    csr_do_d = {17'd0, max_bursts_q};
        3'd3:    csr_do_d = 32'({act_base_q, 5'd0});
        3'd4:    csr_do_d = {17'd0, done_bursts_q};
`ifdef BT656OUT_UNDERRUN_EN
        3'd5:    csr_do_d = {16'd0, urun_cnt_q};
`endif
        default: csr_do_d = '0;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q       <= ST_IDLE;
      enable_q      <= 1'b0;
      pend_base_q   <= '0;
      act_base_q    <= '0;
      adr_q         <= '0;
      max_bursts_q  <= MAX_BURSTS_RST;
      burst_cnt_q   <= '0;
      done_bursts_q <= '0;
      last_q        <= 1'b0;
      irq_q         <= 1'b0;
      csr_do_q      <= '0;
    end else begin
      state_q       <= state_d;
      enable_q      <= enable_d;
      pend_base_q   <= pend_base_d;
      act_base_q    <= act_base_d;
      adr_q         <= adr_d;
      max_bursts_q  <= max_bursts_d;
      burst_cnt_q   <= burst_cnt_d;
      done_bursts_q <= done_bursts_d;
      last_q        <= last_d;
      irq_q         <= irq_d;
      csr_do_q      <= csr_do_d;
    end
  end

  assign csr_do     = csr_do_q;
  assign irq        = irq_q;
  assign enable     = enable_q;
  assign fml_adr    = {adr_q, 5'd0};
  assign last_burst = last_q;

endmodule

// File: tb/tb_bt656out_ctlif.sv
// Bench for bt656out_ctlif: frame-level reference model checked every cycle, plus directed literal checks.
module tb_bt656out_ctlif;

  localparam logic [31:0] ADR_MASK = 32'h03ff_ffff;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [13:0] csr_a = '0;
  logic        csr_we = 1'b0;
  logic [31:0] csr_di = '0;
  logic [31:0] csr_do;
  logic        irq;
  logic        enable;
  logic        start_of_frame = 1'b0;
  logic        next_burst = 1'b0;
  logic [25:0] fml_adr;
  logic        last_burst;
  logic        underrun = 1'b0;

  bt656out_ctlif dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .csr_a         (csr_a),
    .csr_we        (csr_we),
    .csr_di        (csr_di),
    .csr_do        (csr_do),
    .irq           (irq),
    .enable        (enable),
    .start_of_frame(start_of_frame),
    .next_burst    (next_burst),
    .fml_adr       (fml_adr),
    .last_burst    (last_burst),
    .underrun      (underrun)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame = count of accepted bursts against max_bursts.
  logic        m_en, m_in, m_irq;
  logic [31:0] m_pend, m_act, m_adr, m_csr_do;
  logic [31:0] m_max, m_cnt, m_done, m_urun;
  logic        chk_en = 1'b0;

  always @(posedge sys_clk) begin : model
    logic sof_ok;
    logic was_in;
    if (sys_rst) begin
      m_en = 0; m_in = 0; m_irq = 0;
      m_pend = 0; m_act = 0; m_adr = 0; m_csr_do = 0;
      m_max = 12960; m_cnt = 0; m_done = 0; m_urun = 0;
    end else begin
      m_csr_do = 0;
      if (csr_a[13:10] == 4'h0) begin
        case (csr_a[2:0])
          3'd0: m_csr_do = {30'd0, m_in, m_en};
          3'd1: m_csr_do = m_pend;
          3'd2: m_csr_do = m_max;
          3'd3: m_csr_do = m_act;
          3'd4: m_csr_do = m_done;
`ifdef BT656OUT_UNDERRUN_EN
          3'd5: m_csr_do = m_urun;
`endif
          default: m_csr_do = 0;
        endcase
      end
      m_irq  = 0;
      was_in = m_in;
      sof_ok = start_of_frame && m_en && (m_max != 0);
      if (sof_ok) begin
        m_done = m_cnt;
        m_cnt  = 0;
        m_act  = m_pend;
        m_adr  = m_pend;
        m_in   = 1;
      end else if (next_burst && m_in) begin
        m_cnt = m_cnt + 1;
        if (m_cnt == m_max) begin
          m_in  = 0;
          m_irq = 1;
        end else begin
          m_adr = (m_adr + 32) & ADR_MASK;
        end
      end
`ifdef BT656OUT_UNDERRUN_EN
      if (csr_we && csr_a[13:10] == 4'h0 && csr_a[2:0] == 3'd5) m_urun = 0;
      else if (underrun && was_in && m_urun < 65535) m_urun = m_urun + 1;
`endif
      if (csr_we && csr_a[13:10] == 4'h0) begin
        case (csr_a[2:0])
          3'd0: m_en = csr_di[0];
          3'd1: m_pend = csr_di & ADR_MASK & ~32'h1f;
          3'd2: m_max = {17'd0, csr_di[14:0]};
          default: ;
        endcase
      end
    end
  end

  always @(negedge sys_clk) begin
    if (chk_en) begin
      chk("fml_adr", 32'(fml_adr), m_adr);
      chk("last_burst", 32'(last_burst), 32'(m_in && (m_cnt + 32'd1 == m_max)));
      chk("irq", 32'(irq), 32'(m_irq));
      chk("enable", 32'(enable), 32'(m_en));
      chk("csr_do", csr_do, m_csr_do);
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    csr_a  = {4'h0, 7'd0, a};
    csr_di = d;
    csr_we = 1'b1;
    tick();
    csr_we = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [2:0] a, input logic [31:0] exp);
    csr_a = {4'h0, 7'd0, a};
    tick();
    chk(name, csr_do, exp);
  endtask

  task automatic sof();
    start_of_frame = 1'b1;
    tick();
    start_of_frame = 1'b0;
  endtask

  task automatic nb();
    next_burst = 1'b1;
    tick();
    next_burst = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_csr_do", csr_do, 32'h0);
    chk("rst_fml_adr", 32'(fml_adr), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_enable", 32'(enable), 32'h0);
    chk("rst_last", 32'(last_burst), 32'h0);
    chk_en  = 1'b1;
    sys_rst = 1'b0;
    rd_chk("rst_max_bursts", 3'd2, 32'd12960);
    rd_chk("rst_ctrl", 3'd0, 32'd0);

    // Basic three-burst frame with a mid-frame base write.
    wr(3'd0, 32'h1);
    wr(3'd1, 32'h0010_0000);
    wr(3'd2, 32'd3);
    rd_chk("ctrl_en", 3'd0, 32'd1);
    sof();
    chk("f1_adr0", 32'(fml_adr), 32'h0010_0000);
    chk("f1_last0", 32'(last_burst), 32'h0);
    nb();
    chk("f1_adr1", 32'(fml_adr), 32'h0010_0020);
    wr(3'd1, 32'h0020_0000);
    nb();
    chk("f1_adr2", 32'(fml_adr), 32'h0010_0040);
    chk("f1_last2", 32'(last_burst), 32'h1);
    nb();
    chk("f1_irq", 32'(irq), 32'h1);
    tick();
    chk("f1_irq_end", 32'(irq), 32'h0);
    rd_chk("f1_ctrl_idle", 3'd0, 32'd1);
    rd_chk("f1_active", 3'd3, 32'h0010_0000);

    // Next frame picks up the new base; restart mid-frame captures partial count.
    sof();
    chk("f2_adr0", 32'(fml_adr), 32'h0020_0000);
    rd_chk("f2_active", 3'd3, 32'h0020_0000);
    rd_chk("f2_done", 3'd4, 32'd3);
    wr(3'd2, 32'd10);
    repeat (4) nb();
    chk("f2_adr4", 32'(fml_adr), 32'h0020_0080);
    sof();
    chk("restart_irq", 32'(irq), 32'h0);
    chk("restart_adr", 32'(fml_adr), 32'h0020_0000);
    rd_chk("restart_done", 3'd4, 32'd4);
    nb();
    nb();
    start_of_frame = 1'b1;
    next_burst     = 1'b1;
    tick();
    start_of_frame = 1'b0;
    next_burst     = 1'b0;
    chk("coll_adr", 32'(fml_adr), 32'h0020_0000);
    rd_chk("coll_done", 3'd4, 32'd2);
    sof();
    rd_chk("coll_cnt0", 3'd4, 32'd0);
    repeat (10) nb();
    chk("f3_irq", 32'(irq), 32'h1);
    chk("f3_adr", 32'(fml_adr), 32'h0020_0120);

    // Ignored frame starts.
    wr(3'd0, 32'h0);
    sof();
    rd_chk("dis_ctrl", 3'd0, 32'd0);
    nb();
    chk("dis_adr", 32'(fml_adr), 32'h0020_0120);
    wr(3'd0, 32'h1);
    wr(3'd2, 32'd0);
    sof();
    rd_chk("max0_ctrl", 3'd0, 32'd1);
    nb();
    chk("max0_adr", 32'(fml_adr), 32'h0020_0120);

    // Clearing enable mid-frame lets the frame finish.
    wr(3'd2, 32'd2);
    sof();
    wr(3'd0, 32'h0);
    nb();
    chk("dis_mid_last", 32'(last_burst), 32'h1);
    nb();
    chk("dis_mid_irq", 32'(irq), 32'h1);
    sof();
    rd_chk("dis_mid_ctrl", 3'd0, 32'd0);

    // Address wrap at the top of the FML space.
    wr(3'd0, 32'h1);
    wr(3'd1, 32'h03ff_ffe0);
    wr(3'd2, 32'd3);
    sof();
    chk("wrap_adr0", 32'(fml_adr), 32'h03ff_ffe0);
    nb();
    chk("wrap_adr1", 32'(fml_adr), 32'h0);
    nb();
    chk("wrap_adr2", 32'(fml_adr), 32'h20);
    nb();
    chk("wrap_irq", 32'(irq), 32'h1);

    // Bank select and read-during-write.
    csr_a = {4'h1, 7'd0, 3'd2};
    tick();
    chk("other_bank_rd", csr_do, 32'h0);
    csr_di = 32'd5;
    csr_we = 1'b1;
    tick();
    csr_we = 1'b0;
    rd_chk("other_bank_wr", 3'd2, 32'd3);
    wr(3'd2, 32'd9);
    chk("rd_during_wr", csr_do, 32'd3);
    rd_chk("after_wr", 3'd2, 32'd9);

    // Underrun accounting: two pulses idle, five in frame.
    underrun = 1'b1;
    tick();
    underrun = 1'b0;
    tick();
    underrun = 1'b1;
    tick();
    underrun = 1'b0;
    sof();
    repeat (5) begin
      underrun = 1'b1;
      tick();
      underrun = 1'b0;
      tick();
    end
`ifdef BT656OUT_UNDERRUN_EN
    rd_chk("urun_5", 3'd5, 32'd5);
    wr(3'd5, 32'h0);
    rd_chk("urun_clr", 3'd5, 32'd0);
    underrun = 1'b1;
    repeat (70000) tick();
    underrun = 1'b0;
    rd_chk("urun_sat", 3'd5, 32'd65535);
    underrun = 1'b1;
    wr(3'd5, 32'h0);
    underrun = 1'b0;
    rd_chk("urun_wr_wins", 3'd5, 32'd0);
`else
    rd_chk("urun_absent", 3'd5, 32'd0);
`endif

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bt656out_ctlif.md
BT656OUT_CTLIF -- requirements
Module: bt656out_ctlif

Interface
REQ-001 SHALL have parameter csr_addr, default 4'h0, CSR bank select compared with csr_a[13:10].
REQ-002 SHALL have parameter fml_depth, default 26, FML byte-address width.
REQ-003 SHALL have port sys_clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port sys_rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port csr_a  input  14  CSR address.
REQ-006 SHALL have port csr_we  input  1  CSR write strobe.
REQ-007 SHALL have port csr_di  input  32  CSR write data.
REQ-008 SHALL have port csr_do  output  32  CSR read data, registered.
REQ-009 SHALL have port irq  output  1  end-of-frame pulse.
REQ-010 SHALL have port enable  output  1  output-path enable to pixel generator.
REQ-011 SHALL have port start_of_frame  input  1  one-cycle pulse from generator at field/frame start.
REQ-012 SHALL have port next_burst  input  1  one-cycle pulse: burst at fml_adr accepted by FML reader.
REQ-013 SHALL have port fml_adr  output  fml_depth  byte address of next read burst, bits [4:0] always 0.
REQ-014 SHALL have port last_burst  output  1  fml_adr is final burst of the frame.
REQ-015 SHALL have port underrun  input  1  one-cycle pulse: pixel FIFO empty when a pixel was required.

Function
REQ-016 SHALL select the bank when csr_a[13:10]==csr_addr; registers decoded on csr_a[2:0].
REQ-017 SHALL return csr_do one cycle after address; 0 when not selected or address unmapped.
REQ-018 SHALL map: 0 control (bit0 enable; read {in_frame,enable}); 1 pending base (bits [fml_depth-1:5], read back with 5 zero LSBs); 2 max_bursts (15 bits); 3 active base (read-only); 4 done_bursts (read-only, 15 bits); 5 underrun count.
REQ-019 SHALL double-buffer the base: pending base copied to active base only on an accepted start_of_frame; writes mid-frame do not affect current frame addresses.
REQ-020 SHALL accept start_of_frame only when enable=1 and max_bursts!=0; otherwise ignore it entirely.
REQ-021 On accepted start_of_frame: done_bursts<=burst_counter, burst_counter<=0, active base<=pending base, fml_adr<={pending base,5'd0}, in_frame<=1, last_burst<=(max_bursts==1), all next cycle.
REQ-022 On next_burst with in_frame=1 and last_burst=0: burst_counter+1, fml_adr+32, last_burst<=(burst_counter+2==max_bursts).
REQ-023 On next_burst with last_burst=1: burst_counter+1, in_frame<=0, last_burst<=0, irq=1 for exactly the following cycle.
REQ-024 SHALL ignore next_burst when in_frame=0.
REQ-025 start_of_frame simultaneous with next_burst: start_of_frame wins, next_burst dropped.
REQ-026 start_of_frame while in_frame=1: restarts frame per REQ-021, done_bursts captures partial count, no irq.
REQ-027 fml_adr arithmetic SHALL wrap modulo 2^fml_depth without error.
REQ-028 Clearing enable mid-frame SHALL not abort the frame; it blocks only the next start_of_frame.
REQ-029 CSR write to an address and concurrent read of it SHALL return the pre-write value.

Reset
REQ-030 On sys_rst: csr_do=0, irq=0, enable=0, in_frame=0, last_burst=0, fml_adr=0, pending/active base=0, max_bursts=12960, burst_counter=0, done_bursts=0, underrun count=0.

Configuration
REQ-031 Macro BT656OUT_UNDERRUN_EN defined: register 5 is a 16-bit counter incremented on underrun while in_frame=1, saturating at 65535, cleared by any write to register 5 (write wins over increment).
REQ-032 Macro BT656OUT_UNDERRUN_EN undefined: underrun input ignored, no counter logic, register 5 reads 0.

Verification
REQ-033 Reset, read reg 2 -> 12960; read reg 0 -> 0; fml_adr=0, irq=0.
REQ-034 enable=1, base=0x100000, max_bursts=3, start_of_frame, 3 next_burst -> fml_adr 0x100000,0x100020,0x100040; last_burst high on third address only; single irq pulse after third; in_frame=0.
REQ-035 Write base=0x200000 mid-frame -> remaining addresses continue from 0x100000 region; next frame starts at 0x200000; reg 3 updates at that start.
REQ-036 max_bursts=10, start_of_frame after 4 bursts -> reg 4 reads 4, no irq, fml_adr back to base; simultaneous start_of_frame+next_burst -> counter 0.
REQ-037 enable=0 or max_bursts=0, start_of_frame -> in_frame stays 0, next_burst ignored, fml_adr unchanged.
REQ-038 With BT656OUT_UNDERRUN_EN: 5 underrun pulses in frame, 2 outside -> reg 5 reads 5; write reg 5 -> 0; 70000 pulses -> 65535.
